// File: rtl/grf_wb_buffer_if.sv
// Writeback buffer bus: producer request handshake, register-file write port,
// forwarding lookup and occupancy status.
//   master: drives requests, drain_hold and read addresses; sees the rest.
//   slave : the buffer itself.
interface grf_wb_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [4:0]    in_addr;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          drain_hold;
    logic          WriteEnable;
    logic [4:0]    WriteAddress;
    logic [31:0]   WriteData;
    logic [4:0]    ReadAddress1;
    logic [4:0]    ReadAddress2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [31:0]   fwd_data1;
    logic [31:0]   fwd_data2;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output in_valid, in_addr, in_data, drain_hold, ReadAddress1, ReadAddress2,
        input  in_ready, WriteEnable, WriteAddress, WriteData,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_hold, ReadAddress1, ReadAddress2,
        output in_ready, WriteEnable, WriteAddress, WriteData,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty
    );
endinterface

// File: rtl/grf_wb_buffer.sv
// Register-file writeback buffer: a circular FIFO of pending (addr, data)
// writes that drains one entry per cycle into the register file and forwards
// the newest pending value for two read ports.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   Reset_n - asynchronous active-low reset
//   bus     - grf_wb_buffer_if.slave (request, write port, forwarding, status)
module grf_wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset_n,
    grf_wb_buffer_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : gBadDepth
        $error("grf_wb_buffer: DEPTH must be 2, 4 or 8");
    end

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] entryValid;
    logic [4:0]       entryAddr [DEPTH];
    logic [31:0]      entryData [DEPTH];

    logic isEmpty;
    logic isFull;
    logic accept;
    logic store;
    logic pop;

    // Handshake and drain decisions; ready never looks at a same-cycle pop.
    assign isEmpty = (count == '0);
    assign isFull  = (count == CW'(DEPTH));
    assign accept  = bus.in_valid && !isFull;
    assign store   = accept && (bus.in_addr != 5'd0);
    assign pop     = !isEmpty && !bus.drain_hold;

    assign bus.in_ready     = !isFull;
    assign bus.WriteEnable  = pop;
    assign bus.WriteAddress = isEmpty ? 5'd0  : entryAddr[head];
    assign bus.WriteData    = isEmpty ? 32'd0 : entryData[head];
    assign bus.count        = count;
    assign bus.empty        = isEmpty;

    // FIFO state: push at tail, pop at head; pointers wrap by width (DEPTH is 2^AW).
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            entryValid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entryAddr[i] <= 5'd0;
                entryData[i] <= 32'd0;
            end
        end else begin
            if (store) begin
                entryValid[tail] <= 1'b1;
                entryAddr[tail]  <= bus.in_addr;
                entryData[tail]  <= bus.in_data;
                tail             <= tail + AW'(1);
            end
            if (pop) begin
                // Full blocks store, so head==tail cannot collide here.
                entryValid[head] <= 1'b0;
                head             <= head + AW'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    logic [AW-1:0] fwdIdx;
    logic          hit1;
    logic          hit2;
    logic [31:0]   data1;
    logic [31:0]   data2;

    // Walk oldest to newest so the last match (closest to tail) wins.
    always_comb begin
        fwdIdx = '0;
        hit1   = 1'b0;
        hit2   = 1'b0;
        data1  = 32'd0;
        data2  = 32'd0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwdIdx = head + AW'(i);
            if (entryValid[fwdIdx] && (bus.ReadAddress1 != 5'd0)
                && (entryAddr[fwdIdx] == bus.ReadAddress1)) begin
                hit1  = 1'b1;
                data1 = entryData[fwdIdx];
            end
            if (entryValid[fwdIdx] && (bus.ReadAddress2 != 5'd0)
                && (entryAddr[fwdIdx] == bus.ReadAddress2)) begin
                hit2  = 1'b1;
                data2 = entryData[fwdIdx];
            end
        end
    end

    assign bus.fwd_hit1  = hit1;
    assign bus.fwd_hit2  = hit2;
    assign bus.fwd_data1 = data1;
    assign bus.fwd_data2 = data2;
endmodule

// File: tb/tb_grf_wb_buffer.sv
// Self-checking bench for grf_wb_buffer (DEPTH=4): a queue model of pending
// writes is updated every falling edge and compared against the DUT outputs.
module tb_grf_wb_buffer;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic Reset_n;

    grf_wb_buffer_if #(.DEPTH(DEPTH)) bus ();

    grf_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t sbQueue [$];
    int        checkCount = 0;
    int        passCount  = 0;

    task automatic checkVal(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    endtask

    // Newest pending entry with this address; address 0 never matches.
    task automatic modelFwd(input logic [4:0] ra, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        if (ra != 5'd0) begin
            foreach (sbQueue[i]) begin
                if (sbQueue[i].addr == ra) begin
                    hit  = 1'b1;
                    data = sbQueue[i].data;
                end
            end
        end
    endtask

    // Model check + update, away from the rising edge that will act on these inputs.
    always @(negedge clk) begin
        logic        expReady;
        logic        expWe;
        logic        h;
        logic [31:0] d;
        wb_entry_t   e;
        if (!Reset_n) begin
            sbQueue.delete();
            checkVal("rst_we",    32'(bus.WriteEnable), 32'd0);
            checkVal("rst_count", 32'(bus.count),       32'd0);
            checkVal("rst_empty", 32'(bus.empty),       32'd1);
            checkVal("rst_ready", 32'(bus.in_ready),    32'd1);
            checkVal("rst_waddr", 32'(bus.WriteAddress), 32'd0);
            checkVal("rst_wdata", bus.WriteData,        32'd0);
            checkVal("rst_hit1",  32'(bus.fwd_hit1),    32'd0);
            checkVal("rst_hit2",  32'(bus.fwd_hit2),    32'd0);
            checkVal("rst_fd1",   bus.fwd_data1,        32'd0);
            checkVal("rst_fd2",   bus.fwd_data2,        32'd0);
        end else begin
            expReady = (sbQueue.size() < DEPTH);
            expWe    = (sbQueue.size() > 0) && !bus.drain_hold;
            checkVal("in_ready", 32'(bus.in_ready),    32'(expReady));
            checkVal("we",       32'(bus.WriteEnable), 32'(expWe));
            checkVal("count",    32'(bus.count),       32'(sbQueue.size()));
            checkVal("empty",    32'(bus.empty),       32'(sbQueue.size() == 0));
            modelFwd(bus.ReadAddress1, h, d);
            checkVal("fwd_hit1",  32'(bus.fwd_hit1), 32'(h));
            checkVal("fwd_data1", bus.fwd_data1,     d);
            modelFwd(bus.ReadAddress2, h, d);
            checkVal("fwd_hit2",  32'(bus.fwd_hit2), 32'(h));
            checkVal("fwd_data2", bus.fwd_data2,     d);
            if (sbQueue.size() > 0) begin
                checkVal("waddr", 32'(bus.WriteAddress), 32'(sbQueue[0].addr));
                checkVal("wdata", bus.WriteData,         sbQueue[0].data);
            end else begin
                checkVal("waddr_idle", 32'(bus.WriteAddress), 32'd0);
                checkVal("wdata_idle", bus.WriteData,         32'd0);
            end
            if (expWe) void'(sbQueue.pop_front());
            if (bus.in_valid && expReady && bus.in_addr != 5'd0) begin
                e.addr = bus.in_addr;
                e.data = bus.in_data;
                sbQueue.push_back(e);
            end
        end
    end

    // Present one cycle of inputs just after a rising edge.
    task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic hold);
        @(posedge clk);
        #1;
        bus.in_valid   = v;
        bus.in_addr    = a;
        bus.in_data    = d;
        bus.drain_hold = hold;
    endtask

    initial begin
        Reset_n          = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_addr      = 5'd0;
        bus.in_data      = 32'd0;
        bus.drain_hold   = 1'b0;
        bus.ReadAddress1 = 5'd0;
        bus.ReadAddress2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1'b1;

        // Single write: visible the cycle after acceptance, gone after the next edge.
        cyc(1'b1, 5'd5, 32'h1234_5678, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("single_we",    32'(bus.WriteEnable),  32'd1);
        checkVal("single_waddr", 32'(bus.WriteAddress), 32'd5);
        checkVal("single_wdata", bus.WriteData,         32'h1234_5678);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("single_empty", 32'(bus.empty), 32'd1);

        // Fill under drain_hold, refuse a fifth, then drain in order.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1);
        cyc(1'b1, 5'd9, 32'hDEAD, 1'b1);
        checkVal("full_count", 32'(bus.count),    32'd4);
        checkVal("full_ready", 32'(bus.in_ready), 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1);
        checkVal("hold_count", 32'(bus.count),    32'd4);
        checkVal("hold_waddr", 32'(bus.WriteAddress), 32'd1);
        repeat (5) cyc(1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("drained_empty", 32'(bus.empty), 32'd1);

        // Forwarding picks the newest of two writes to r7; r0 never hits.
        bus.ReadAddress1 = 5'd7;
        bus.ReadAddress2 = 5'd0;
        cyc(1'b1, 5'd7, 32'hA, 1'b1);
        cyc(1'b1, 5'd7, 32'hB, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1);
        checkVal("fwd_newest_hit",  32'(bus.fwd_hit1), 32'd1);
        checkVal("fwd_newest_data", bus.fwd_data1,     32'hB);
        checkVal("fwd_r0_hit",      32'(bus.fwd_hit2), 32'd0);
        bus.ReadAddress2 = 5'd7;
        repeat (3) cyc(1'b0, 5'd0, 32'd0, 1'b0);

        // Address 0 is handshaken and dropped.
        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        checkVal("r0_ready", 32'(bus.in_ready), 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("r0_count", 32'(bus.count),       32'd0);
        checkVal("r0_we",    32'(bus.WriteEnable), 32'd0);

        // Steady stream: one in, one out per cycle, pointers wrap several times.
        bus.ReadAddress1 = 5'd3;
        for (int i = 0; i < 12; i++) cyc(1'b1, 5'((i % 31) + 1), $urandom, 1'b0);
        checkVal("stream_count", 32'(bus.count), 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);

        // Async reset mid-operation with three entries pending.
        bus.ReadAddress1 = 5'd21;
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        checkVal("pre_rst_we",    32'(bus.WriteEnable), 32'd1);
        checkVal("pre_rst_count", 32'(bus.count),       32'd3);
        Reset_n = 1'b0;
        #1;
        checkVal("async_rst_we",    32'(bus.WriteEnable), 32'd0);
        checkVal("async_rst_count", 32'(bus.count),       32'd0);
        checkVal("async_rst_empty", 32'(bus.empty),       32'd1);
        checkVal("async_rst_hit1",  32'(bus.fwd_hit1),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1'b1;
        repeat (4) cyc(1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("post_rst_empty", 32'(bus.empty), 32'd1);

        // Bounded wait for anything the model still expects to drain.
        for (int i = 0; i < 20 && sbQueue.size() != 0; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0);
        checkVal("final_drain", 32'(sbQueue.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/grf_wb_buffer.md
GRF_WB_BUFFER -- requirements
Module: grf_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of pending writeback entries; legal values are 2, 4 or 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: a writeback request is presented.
REQ-005 SHALL have port in_addr, input, 5 bits: destination register number.
REQ-006 SHALL have port in_data, input, 32 bits: writeback value.
REQ-007 SHALL have port in_ready, output, 1 bit: the buffer accepts the request this cycle.
REQ-008 SHALL have port drain_hold, input, 1 bit: inhibits draining to the register file.
REQ-009 SHALL have port WriteEnable, output, 1 bit: register-file write strobe.
REQ-010 SHALL have port WriteAddress, output, 5 bits: register-file write address.
REQ-011 SHALL have port WriteData, output, 32 bits: register-file write data.
REQ-012 SHALL have ports ReadAddress1 and ReadAddress2, input, 5 bits each: addresses being read from the register file this cycle.
REQ-013 SHALL have ports fwd_hit1 and fwd_hit2, output, 1 bit each: a pending entry matches the corresponding read address.
REQ-014 SHALL have ports fwd_data1 and fwd_data2, output, 32 bits each: forwarded value for the corresponding read address.
REQ-015 SHALL have port count, output, log2(DEPTH)+1 bits: number of valid entries.
REQ-016 SHALL have port empty, output, 1 bit: count==0.

Function
REQ-017 SHALL implement a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus a count register.
REQ-018 SHALL drive in_ready = (count < DEPTH), combinationally, with no dependence on in_valid or on a same-cycle drain.
REQ-019 SHALL accept a request on a rising edge only when in_valid && in_ready are both high.
REQ-020 SHALL discard an accepted request with in_addr==0: it is handshaken but not stored, and the tail and count are unchanged.
REQ-021 SHALL drive WriteEnable = !empty && !drain_hold, and WriteAddress/WriteData = the head entry, all combinationally; WriteAddress/WriteData = 0 when empty.
REQ-022 SHALL pop the head on the rising edge where WriteEnable is 1.
- Latency: a request accepted at edge N is visible on WriteEnable in cycle N+1 at the earliest, and is written into the register file at edge N+1.
REQ-023 SHALL, on a simultaneous accept (non-zero address) and pop, advance both pointers and leave count unchanged.
REQ-024 SHALL never pop when empty and never store when full; handshake violations are impossible by construction.
REQ-025 SHALL preserve write order: entries drain strictly in acceptance order, including repeated writes to the same address.
REQ-026 SHALL set fwd_hitK=1 when any valid entry, the head included, has address == ReadAddressK and ReadAddressK != 0.
REQ-027 SHALL drive fwd_dataK = data of the newest (closest to tail) matching entry, or 0 when there is no hit.
REQ-028 SHALL compute forwarding from the state before the current edge: a request being accepted in the same cycle does not forward.
REQ-029 SHALL hold all entries, count and outputs stable while drain_hold=1 and there is no accept.

Reset
REQ-030 SHALL, when Reset_n=0, asynchronously clear head, tail and count to 0, invalidate all entries, and clear entry data to 0.
REQ-031 SHALL hold the following output values while in reset: WriteEnable=0, WriteAddress=0, WriteData=0, fwd_hit1/2=0, fwd_data1/2=0, count=0, empty=1, in_ready=1.
REQ-032 SHALL lose any in-flight entries when Reset_n is asserted mid-operation, with no write issued afterward.
REQ-033 SHALL resume normal operation on the first rising edge after Reset_n deasserts.

Verification
REQ-034 Single write: accept (addr 5, 0x1234_5678) at edge 1 -> cycle 2 shows WriteEnable=1, WriteAddress=5, WriteData=0x12345678; empty=1 after edge 2.
REQ-035 Fill/overflow: drain_hold=1, accept 4 writes to r1..r4 -> count=4, in_ready=0; a 5th in_valid is not accepted; release drain_hold -> r1..r4 drain in order over 4 cycles.
REQ-036 Forward newest: queue r7=0xA then r7=0xB, with ReadAddress1=7 -> fwd_hit1=1, fwd_data1=0xB; ReadAddress2=0 -> fwd_hit2=0.
REQ-037 $0 discard: accept addr 0 with 0xFFFF_FFFF -> in_ready handshake completes, count stays 0, no WriteEnable pulse.
REQ-038 Steady stream: in_valid every cycle with drain_hold=0 -> count stays at 1, one write per cycle, order preserved, pointers wrap past DEPTH-1.
REQ-039 Async reset: with 3 entries pending, pull Reset_n low between edges -> WriteEnable=0, count=0, empty=1 immediately, with no write issued after reset is released.
